// File: rtl/baud_cfg_ctrl.sv
// Baud-rate reconfiguration controller.
// Accepts a baud index, waits for the UART transmitter and receiver to go
// idle (bounded by a timeout), then loads the new divider limit while
// holding the divider in reset for a fixed number of cycles.
//
// Handshake: a request transfers on a rising edge where cfg_valid=1 and
// cfg_ready=1. cfg_sel is captured on that edge only. cfg_ready is 1 only
// while the controller sits in RUN. Outcomes are reported as one-cycle
// pulses: cfg_done when a new configuration takes effect, cfg_err when a
// request is rejected (index 7) or aborted by the drain timeout.
module baud_cfg_ctrl #(
  parameter logic [2:0]  DEFAULT_SEL   = 3'd0,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned DRAIN_TIMEOUT = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        resetn,
  input  logic        cfg_valid,
  input  logic [2:0]  cfg_sel,
  output logic        cfg_ready,
  input  logic        tx_busy,
  input  logic        rx_busy,
  output logic [11:0] count_lim,
  output logic        div_resetn,
  output logic [2:0]  active_sel,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Terminal counts for the HOLD and DRAIN counters.
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [19:0] DRAIN_LAST = 20'(DRAIN_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic [19:0] drain_cnt;
  logic [2:0]  sel_q;

  // Half-period divider limit for a 16x oversample clock from 100 MHz.
  function automatic logic [11:0] lim_of(input logic [2:0] s);
    case (s)
      3'd0:    return 12'd326;  // 9600
      3'd1:    return 12'd163;  // 19200
      3'd2:    return 12'd81;   // 38400
      3'd3:    return 12'd54;   // 57600
      3'd4:    return 12'd27;   // 115200
      3'd5:    return 12'd14;   // 230400
      3'd6:    return 12'd7;    // 460800
      default: return 12'd0;    // index 7 is rejected before it is ever loaded
    endcase
  endfunction

  // State is visible for checkers and debug.
  assign fsm_state = state;

  // Reconfiguration FSM; every output is a register updated here.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_HOLD;
      hold_cnt   <= 8'd0;
      drain_cnt  <= 20'd0;
      sel_q      <= DEFAULT_SEL;
      count_lim  <= lim_of(DEFAULT_SEL);
      active_sel <= DEFAULT_SEL;
      div_resetn <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        ST_RUN: begin
          if (cfg_valid && cfg_ready) begin
            if (cfg_sel == 3'd7) begin
              // Invalid index: reject, keep running with the current setup.
              cfg_err <= 1'b1;
            end else begin
              sel_q     <= cfg_sel;
              drain_cnt <= 20'd0;
              cfg_ready <= 1'b0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Idle takes priority over a coincident timeout.
          if (!tx_busy && !rx_busy) begin
            count_lim  <= lim_of(sel_q);
            active_sel <= sel_q;
            div_resetn <= 1'b0;
            hold_cnt   <= 8'd0;
            state      <= ST_HOLD;
          end else if (drain_cnt == DRAIN_LAST) begin
            cfg_err   <= 1'b1;
            cfg_ready <= 1'b1;
            state     <= ST_RUN;
          end else begin
            drain_cnt <= drain_cnt + 20'd1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            div_resetn <= 1'b1;
            cfg_done   <= 1'b1;
            cfg_ready  <= 1'b1;
            state      <= ST_RUN;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          div_resetn <= 1'b0;
          hold_cnt   <= 8'd0;
          cfg_ready  <= 1'b0;
          state      <= ST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Bench for baud_cfg_ctrl: directed vector table, reset corner cases and a
// randomized request stream checked against a transaction-level model.
module tb_baud_cfg_ctrl;

  localparam int HOLD = 4;
  localparam int TMO  = 10;

  // Clock / reset
  logic        CLK100MHZ = 1'b0;
  logic        resetn    = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_sel   = 3'd0;
  logic        tx_busy   = 1'b0;
  logic        rx_busy   = 1'b0;
  logic        cfg_ready;
  logic [11:0] count_lim;
  logic        div_resetn;
  logic [2:0]  active_sel;
  logic        cfg_done;
  logic        cfg_err;
  logic [1:0]  fsm_state;

  always #5 CLK100MHZ = ~CLK100MHZ;

  baud_cfg_ctrl #(
    .DEFAULT_SEL  (3'd0),
    .HOLD_CYCLES  (HOLD),
    .DRAIN_TIMEOUT(TMO)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .resetn    (resetn),
    .cfg_valid (cfg_valid),
    .cfg_sel   (cfg_sel),
    .cfg_ready (cfg_ready),
    .tx_busy   (tx_busy),
    .rx_busy   (rx_busy),
    .count_lim (count_lim),
    .div_resetn(div_resetn),
    .active_sel(active_sel),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .fsm_state (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int model_active = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [2:0]  sel;
    int          busy_n;
    logic [1:0]  mask;   // bit0 drives tx_busy, bit1 drives rx_busy
    bit          ok;
    logic [11:0] lim;
    logic [2:0]  act;
  } vec_t;

  // Reference: lim = round(100e6 / (32 * baud)).
  function automatic int ref_lim(input int sel);
    int baud_tab[7] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800};
    int b;
    b = baud_tab[sel];
    return (100_000_000 + 16 * b) / (32 * b);
  endfunction

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: reset, release, and check the start-up HOLD sequence.
  task automatic do_reset();
    int low_n, done_n, done_k, err_n;
    @(negedge CLK100MHZ);
    resetn    = 1'b0;
    cfg_valid = 1'b0;
    tx_busy   = 1'b0;
    rx_busy   = 1'b0;
    #1;
    chk("rst_count_lim", count_lim, 32'(ref_lim(0)));
    chk("rst_active_sel", active_sel, 0);
    chk("rst_div_resetn", div_resetn, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(negedge CLK100MHZ);
    @(negedge CLK100MHZ);
    resetn = 1'b1;
    #1;
    low_n = (div_resetn === 1'b0) ? 1 : 0;
    done_n = 0; done_k = 0; err_n = 0;
    for (int k = 1; k <= HOLD + 6; k++) begin
      @(negedge CLK100MHZ);
      if (div_resetn === 1'b0) low_n++;
      if (cfg_done === 1'b1) begin done_n++; done_k = k; end
      if (cfg_err === 1'b1) err_n++;
    end
    chk("boot_low_cycles", low_n, HOLD);
    chk("boot_done_count", done_n, 1);
    chk("boot_done_cycle", done_k, HOLD);
    chk("boot_err_count", err_n, 0);
    chk("boot_ready", cfg_ready, 1);
    chk("boot_div_resetn", div_resetn, 1);
    chk("boot_count_lim", count_lim, 32'(ref_lim(0)));
    model_active = 0;
  endtask

  // Driver: issue one request, hold busy for busy_n DRAIN edges, observe.
  task automatic run_req(input logic [2:0] sel, input int busy_n, input logic [1:0] mask,
                         input bit exp_ok, input logic [11:0] exp_lim, input logic [2:0] exp_act);
    int t, win, fall_k, low_n, done_n, done_k, err_n, err_k, both;
    logic [11:0] lim_at_fall;
    logic [2:0]  act_at_fall;
    t = 0;
    @(negedge CLK100MHZ);
    while (cfg_ready !== 1'b1 && t < 50) begin
      @(negedge CLK100MHZ);
      t++;
    end
    chk("ready_before_req", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    tx_busy   = mask[0] && (busy_n > 0);
    rx_busy   = mask[1] && (busy_n > 0);
    win = ((busy_n > TMO) ? busy_n : TMO) + HOLD + 4;
    fall_k = 0; low_n = 0; done_n = 0; done_k = 0; err_n = 0; err_k = 0; both = 0;
    lim_at_fall = '0; act_at_fall = '0;
    for (int k = 1; k <= win; k++) begin
      @(negedge CLK100MHZ);
      if (k == 1) chk("ready_after_accept", cfg_ready, (sel == 3'd7) ? 1 : 0);
      cfg_valid = 1'b0;
      cfg_sel   = 3'($urandom_range(0, 7));
      tx_busy   = mask[0] && (k <= busy_n);
      rx_busy   = mask[1] && (k <= busy_n);
      if (div_resetn === 1'b0) begin
        low_n++;
        if (fall_k == 0) begin
          fall_k = k;
          lim_at_fall = count_lim;
          act_at_fall = active_sel;
        end
      end
      if (cfg_done === 1'b1) begin done_n++; done_k = k; end
      if (cfg_err === 1'b1) begin err_n++; err_k = k; end
      if (cfg_done === 1'b1 && cfg_err === 1'b1) both++;
    end
    tx_busy = 1'b0;
    rx_busy = 1'b0;
    if (exp_ok) begin
      chk("div_resetn_fall_cycle", fall_k, busy_n + 2);
      chk("div_resetn_low_cycles", low_n, HOLD);
      chk("count_lim_at_hold", lim_at_fall, exp_lim);
      chk("active_sel_at_hold", act_at_fall, exp_act);
      chk("done_count", done_n, 1);
      chk("done_cycle", done_k, busy_n + 2 + HOLD);
      chk("err_count", err_n, 0);
    end else begin
      chk("div_resetn_low_cycles", low_n, 0);
      chk("done_count", done_n, 0);
      chk("err_count", err_n, 1);
      chk("err_cycle", err_k, (sel == 3'd7) ? 1 : TMO + 1);
    end
    chk("done_err_overlap", both, 0);
    chk("final_count_lim", count_lim, exp_lim);
    chk("final_active_sel", active_sel, exp_act);
    chk("final_ready", cfg_ready, 1);
  endtask

  initial begin
    vec_t vecs[9];
    logic [2:0]  r_sel;
    int          r_busy;
    logic [1:0]  r_mask;
    bit          r_ok;
    logic [11:0] r_lim;

    vecs[0] = '{sel: 3'd7, busy_n: 0,  mask: 2'b00, ok: 1'b0, lim: 12'd326, act: 3'd0};
    vecs[1] = '{sel: 3'd4, busy_n: 0,  mask: 2'b01, ok: 1'b1, lim: 12'd27,  act: 3'd4};
    vecs[2] = '{sel: 3'd2, busy_n: 12, mask: 2'b01, ok: 1'b0, lim: 12'd27,  act: 3'd4};
    vecs[3] = '{sel: 3'd1, busy_n: 5,  mask: 2'b10, ok: 1'b1, lim: 12'd163, act: 3'd1};
    vecs[4] = '{sel: 3'd1, busy_n: 0,  mask: 2'b00, ok: 1'b1, lim: 12'd163, act: 3'd1};
    vecs[5] = '{sel: 3'd5, busy_n: 9,  mask: 2'b11, ok: 1'b1, lim: 12'd14,  act: 3'd5};
    vecs[6] = '{sel: 3'd3, busy_n: 10, mask: 2'b10, ok: 1'b0, lim: 12'd14,  act: 3'd5};
    vecs[7] = '{sel: 3'd6, busy_n: 2,  mask: 2'b11, ok: 1'b1, lim: 12'd7,   act: 3'd6};
    vecs[8] = '{sel: 3'd0, busy_n: 1,  mask: 2'b01, ok: 1'b1, lim: 12'd326, act: 3'd0};

    do_reset();

    for (int i = 0; i < 9; i++)
      run_req(vecs[i].sel, vecs[i].busy_n, vecs[i].mask, vecs[i].ok, vecs[i].lim, vecs[i].act);
    model_active = 0;

    // Randomized requests against the transaction model.
    for (int i = 0; i < 25; i++) begin
      r_sel  = 3'($urandom_range(0, 7));
      r_busy = $urandom_range(0, TMO + 2);
      r_mask = 2'($urandom_range(1, 3));
      r_ok   = (r_sel != 3'd7) && (r_busy < TMO);
      if (r_ok) model_active = int'(r_sel);
      exp_q.push_back(12'(ref_lim(model_active)));
      r_lim = exp_q.pop_front();
      run_req(r_sel, r_busy, r_mask, r_ok, r_lim, 3'(model_active));
    end

    // Reset in the middle of a HOLD for index 6.
    @(negedge CLK100MHZ);
    chk("midhold_ready", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_sel   = 3'd6;
    @(negedge CLK100MHZ);
    cfg_valid = 1'b0;
    @(negedge CLK100MHZ);
    chk("midhold_div_resetn", div_resetn, 0);
    chk("midhold_count_lim", count_lim, 32'(ref_lim(6)));
    @(negedge CLK100MHZ);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/baud_cfg_ctrl.md
BAUD_CFG_CTRL -- requirements
Module: baud_cfg_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_SEL, default 3'd0: baud select applied at reset.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: cycles div_resetn is held low per reconfiguration; legal range 1..255.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 100000: maximum DRAIN cycles before abort; legal range 1..2^20-1.
REQ-004 SHALL have port CLK100MHZ, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid, input, 1 bit: a reconfiguration request is present.
REQ-007 SHALL have port cfg_sel, input, 3 bits: requested baud index.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the controller can accept a request.
REQ-009 SHALL have port tx_busy, input, 1 bit: the transmitter is mid-frame.
REQ-010 SHALL have port rx_busy, input, 1 bit: the receiver is mid-frame.
REQ-011 SHALL have port count_lim, output, 12 bits: half-period limit fed to the divider.
REQ-012 SHALL have port div_resetn, output, 1 bit: active-low reset to the divider.
REQ-013 SHALL have port active_sel, output, 3 bits: the index currently applied.
REQ-014 SHALL have port cfg_done, output, 1 bit: one-cycle pulse when a new configuration takes effect.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a request is rejected or aborted.

Function
REQ-016 Baud table (16x oversample clock, lim = round(100e6/(32*baud))) SHALL be: sel 0=326 (9600), 1=163 (19200), 2=81 (38400), 3=54 (57600), 4=27 (115200), 5=14 (230400), 6=7 (460800); sel 7 is invalid.
REQ-017 FSM states SHALL be RUN, DRAIN and HOLD; cfg_ready SHALL be 1 only in RUN.
REQ-018 A request SHALL be accepted on a rising edge where cfg_valid=1 and cfg_ready=1; cfg_sel SHALL be captured at that edge, and later changes to cfg_sel SHALL have no effect.
REQ-019 On acceptance of a valid sel, the FSM SHALL move RUN->DRAIN, clear the timeout counter, and leave outputs unchanged.
REQ-020 On acceptance of sel=7, the FSM SHALL stay in RUN and pulse cfg_err in the next cycle; count_lim and active_sel SHALL be unchanged.
REQ-021 In DRAIN, an edge sampling tx_busy=0 and rx_busy=0 SHALL move the FSM to HOLD, and SHALL load count_lim and active_sel from the captured sel at that same edge, with div_resetn=0.
REQ-022 In DRAIN with either busy bit set, the timeout counter SHALL increment; at count DRAIN_TIMEOUT-1 with busy still set, the FSM SHALL go to RUN, pulse cfg_err, and keep the old config; div_resetn SHALL stay 1.
REQ-023 If idle and timeout coincide on the same edge, idle SHALL win and the FSM SHALL go to HOLD.
REQ-024 The FSM SHALL stay in HOLD for exactly HOLD_CYCLES cycles with div_resetn=0, then go to RUN with div_resetn=1 and cfg_done=1 for that first RUN cycle.
REQ-025 Minimum latency, from an accept edge with lines idle to div_resetn falling, SHALL be 2 edges; cfg_done SHALL assert HOLD_CYCLES cycles after that.
REQ-026 Requesting the currently active sel SHALL still perform the full DRAIN/HOLD sequence.
REQ-027 cfg_done and cfg_err SHALL never assert in the same cycle.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While resetn=0: FSM=HOLD, hold counter=0, count_lim=table[DEFAULT_SEL], active_sel=DEFAULT_SEL, div_resetn=0, cfg_ready=0, cfg_done=0, cfg_err=0.
REQ-030 After resetn rises, the block SHALL complete a normal HOLD (HOLD_CYCLES cycles) and enter RUN with a cfg_done pulse.
REQ-031 Reset asserted mid-DRAIN or mid-HOLD SHALL abandon the request immediately; no cfg_done or cfg_err SHALL result from it.

Verification
REQ-032 Bench: reset release, defaults -> count_lim=326, div_resetn=0 for 4 cycles, then div_resetn=1, cfg_done pulse, cfg_ready=1.
REQ-033 Bench: cfg_sel=4 accepted with busy low -> 2 edges later count_lim=27, active_sel=4, div_resetn=0 for 4 cycles, cfg_done 1 cycle.
REQ-034 Bench: cfg_sel=7 accepted -> cfg_err pulse next cycle, count_lim remains 326, FSM stays in RUN.
REQ-035 Bench: DRAIN_TIMEOUT=10, tx_busy held 1, cfg_sel=2 -> cfg_err after 10 DRAIN cycles, count_lim unchanged, div_resetn never 0.
REQ-036 Bench: cfg_sel=1, rx_busy=1 for 5 cycles then 0 -> HOLD entered the edge after release, count_lim=163.
REQ-037 Bench: resetn pulsed low during HOLD of a sel=6 request -> count_lim=326 and the reset sequence restarts with a single cfg_done.
